// File: rtl/blk_sched_pkg.sv
// Shared constants and types for the SD block-buffer scheduler.
// RAM_BLOCKS_DEF : default number of 512-byte buffer blocks
// BLK_BYTES      : size of one buffer block in bytes
// stage_state_e  : per-stage ownership state (idle / holding a block)
package blk_sched_pkg;

    localparam int unsigned RAM_BLOCKS_DEF = 8;
    localparam int unsigned BLK_BYTES      = 512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } stage_state_e;

endpackage : blk_sched_pkg

// File: rtl/blk_stage.sv
// One pipeline stage of the block scheduler: owns at most one block at a time,
// walks its block pointer in FIFO order and flags done pulses with no block held.
// clk_i/rst_i   : clock, synchronous active-high reset (reset or clear)
// req_i, done_i : stage request and completion pulse
// avail_i       : registered source-counter is non-zero
// grant_o       : registered one-cycle grant
// busy_o, ptr_o : stage holds a block / index of that block
// take_o_c      : grant decision this cycle (source counter decrements)
// fin_o_c       : valid done this cycle (next counter increments)
// err_o_c       : done pulse with no block held
module blk_stage
    import blk_sched_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         done_i,
    input  logic         avail_i,
    output logic         grant_o,
    output logic         busy_o,
    output logic [W-1:0] ptr_o,
    output logic         take_o_c,
    output logic         fin_o_c,
    output logic         err_o_c
);

    stage_state_e state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         grant_q, grant_d;

    // State, pointer and grant registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Grant / done handling; a done in the idle state blocks the grant that cycle
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = 1'b0;
        take_o_c = 1'b0;
        fin_o_c  = 1'b0;
        err_o_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (done_i) begin
                    err_o_c = 1'b1;
                end else if (req_i && avail_i) begin
                    take_o_c = 1'b1;
                    grant_d  = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done_i) begin
                    fin_o_c = 1'b1;
                    ptr_d   = ptr_q + W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == ST_BUSY);
    assign ptr_o   = ptr_q;

endmodule : blk_stage

// File: rtl/blk_sched.sv
// Buffer-block scheduler for the SD read -> OTP cipher -> SD write pipeline.
// Blocks circulate free -> raw -> enc -> free; each stage takes one block at a time.
// iclk, irst, iclear              : clock, sync reset, sync abort
// ird_req/ord_grant/ord_blk/ird_done  : read-path handshake
// ienc_req/oenc_grant/oenc_blk/ienc_done : cipher handshake
// iwr_req/owr_grant/owr_blk/iwr_done  : write-path handshake
// ofree_cnt, oall_free, oerr      : free-block count, all-idle flag, sticky error
module blk_sched
    import blk_sched_pkg::*;
#(
    parameter int unsigned RAM_BLOCKS = RAM_BLOCKS_DEF
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          iclear,
    input  logic                          ird_req,
    output logic                          ord_grant,
    output logic [$clog2(RAM_BLOCKS)-1:0] ord_blk,
    input  logic                          ird_done,
    input  logic                          ienc_req,
    output logic                          oenc_grant,
    output logic [$clog2(RAM_BLOCKS)-1:0] oenc_blk,
    input  logic                          ienc_done,
    input  logic                          iwr_req,
    output logic                          owr_grant,
    output logic [$clog2(RAM_BLOCKS)-1:0] owr_blk,
    input  logic                          iwr_done,
    output logic [$clog2(RAM_BLOCKS):0]   ofree_cnt,
    output logic                          oall_free,
    output logic                          oerr
);

    localparam int unsigned W  = $clog2(RAM_BLOCKS);
    localparam int unsigned CW = W + 1;

    logic          rst;
    logic [CW-1:0] n_free_q, n_free_d;
    logic [CW-1:0] n_raw_q, n_raw_d;
    logic [CW-1:0] n_enc_q, n_enc_d;
    logic          all_free_q, all_free_d;
    logic          err_q, err_d;

    logic rd_busy, rd_take, rd_fin, rd_err;
    logic enc_busy, enc_take, enc_fin, enc_err;
    logic wr_busy, wr_take, wr_fin, wr_err;
    logic any_busy_nx;

    assign rst = irst | iclear;

    blk_stage #(.W(W)) u_rd (
        .clk_i    (iclk),
        .rst_i    (rst),
        .req_i    (ird_req),
        .done_i   (ird_done),
        .avail_i  (n_free_q != '0),
        .grant_o  (ord_grant),
        .busy_o   (rd_busy),
        .ptr_o    (ord_blk),
        .take_o_c (rd_take),
        .fin_o_c  (rd_fin),
        .err_o_c  (rd_err)
    );

    blk_stage #(.W(W)) u_enc (
        .clk_i    (iclk),
        .rst_i    (rst),
        .req_i    (ienc_req),
        .done_i   (ienc_done),
        .avail_i  (n_raw_q != '0),
        .grant_o  (oenc_grant),
        .busy_o   (enc_busy),
        .ptr_o    (oenc_blk),
        .take_o_c (enc_take),
        .fin_o_c  (enc_fin),
        .err_o_c  (enc_err)
    );

    blk_stage #(.W(W)) u_wr (
        .clk_i    (iclk),
        .rst_i    (rst),
        .req_i    (iwr_req),
        .done_i   (iwr_done),
        .avail_i  (n_enc_q != '0),
        .grant_o  (owr_grant),
        .busy_o   (wr_busy),
        .ptr_o    (owr_blk),
        .take_o_c (wr_take),
        .fin_o_c  (wr_fin),
        .err_o_c  (wr_err)
    );

    // Busy state each stage will hold after this edge
    assign any_busy_nx = (rd_take  | (rd_busy  & ~rd_fin))
                       | (enc_take | (enc_busy & ~enc_fin))
                       | (wr_take  | (wr_busy  & ~wr_fin));

    // Net counter update: every take and finish in a cycle applies together
    always_comb begin
        n_free_d   = n_free_q - CW'(rd_take)  + CW'(wr_fin);
        n_raw_d    = n_raw_q  - CW'(enc_take) + CW'(rd_fin);
        n_enc_d    = n_enc_q  - CW'(wr_take)  + CW'(enc_fin);
        all_free_d = (n_free_d == CW'(RAM_BLOCKS)) && !any_busy_nx;
        err_d      = err_q | rd_err | enc_err | wr_err;
    end

    // Counter and status registers
    always_ff @(posedge iclk) begin
        if (rst) begin
            n_free_q   <= CW'(RAM_BLOCKS);
            n_raw_q    <= '0;
            n_enc_q    <= '0;
            all_free_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            n_free_q   <= n_free_d;
            n_raw_q    <= n_raw_d;
            n_enc_q    <= n_enc_d;
            all_free_q <= all_free_d;
            err_q      <= err_d;
        end
    end

    assign ofree_cnt = n_free_q;
    assign oall_free = all_free_q;
    assign oerr      = err_q;

endmodule : blk_sched

// File: tb/tb_blk_sched.sv
// Self-checking bench for blk_sched (RAM_BLOCKS=4): directed scenarios plus
// random traffic against a queue-based model of block ownership.
module tb_blk_sched;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 2;

    logic         iclk = 1'b0;
    logic         irst, iclear;
    logic         ird_req, ird_done, ienc_req, ienc_done, iwr_req, iwr_done;
    logic         ord_grant, oenc_grant, owr_grant;
    logic [W-1:0] ord_blk, oenc_blk, owr_blk;
    logic [W:0]   ofree_cnt;
    logic         oall_free, oerr;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: q[0]=free, q[1]=raw, q[2]=enc; stage i takes from q[i], returns to q[(i+1)%3]
    int  q[3][$];
    bit  m_busy[3];
    int  m_blk[3];
    bit  m_grant[3];
    bit  m_err;
    int  seq[3][$];
    string nm[3] = '{"rd", "enc", "wr"};

    always #5 iclk = ~iclk;

    blk_sched #(.RAM_BLOCKS(NB)) dut (
        .iclk       (iclk),
        .irst       (irst),
        .iclear     (iclear),
        .ird_req    (ird_req),
        .ord_grant  (ord_grant),
        .ord_blk    (ord_blk),
        .ird_done   (ird_done),
        .ienc_req   (ienc_req),
        .oenc_grant (oenc_grant),
        .oenc_blk   (oenc_blk),
        .ienc_done  (ienc_done),
        .iwr_req    (iwr_req),
        .owr_grant  (owr_grant),
        .owr_blk    (owr_blk),
        .iwr_done   (iwr_done),
        .ofree_cnt  (ofree_cnt),
        .oall_free  (oall_free),
        .oerr       (oerr)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int obs_grant(input int i);
        case (i)
            0:       return int'(ord_grant);
            1:       return int'(oenc_grant);
            default: return int'(owr_grant);
        endcase
    endfunction

    function automatic int obs_blk(input int i);
        case (i)
            0:       return int'(ord_blk);
            1:       return int'(oenc_blk);
            default: return int'(owr_blk);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            m_busy[i]  = 1'b0;
            m_blk[i]   = 0;
            m_grant[i] = 1'b0;
        end
        for (int b = 0; b < int'(NB); b++) q[0].push_back(b);
        m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        bit req[3], dn[3], g[3], fin[3];
        int sz[3];
        if (irst || iclear) begin
            model_reset();
            return;
        end
        req[0] = ird_req;  req[1] = ienc_req;  req[2] = iwr_req;
        dn[0]  = ird_done; dn[1]  = ienc_done; dn[2]  = iwr_done;
        for (int i = 0; i < 3; i++) begin
            sz[i]  = q[i].size();
            g[i]   = req[i] && !m_busy[i] && (sz[i] > 0) && !dn[i];
            fin[i] = dn[i] && m_busy[i];
            if (dn[i] && !m_busy[i]) m_err = 1'b1;
        end
        for (int i = 0; i < 3; i++)
            if (g[i]) m_blk[i] = q[i].pop_front();
        for (int i = 0; i < 3; i++)
            if (fin[i]) begin
                q[(i + 1) % 3].push_back(m_blk[i]);
                m_busy[i] = 1'b0;
            end
        for (int i = 0; i < 3; i++) begin
            if (g[i]) m_busy[i] = 1'b1;
            m_grant[i] = g[i];
        end
    endtask

    // One clock: update model, then compare all outputs just after the edge
    task automatic cycle();
        bit any_busy;
        model_edge();
        @(posedge iclk);
        #1;
        any_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({nm[i], "_grant"}, obs_grant(i), int'(m_grant[i]));
            if (m_busy[i]) chk({nm[i], "_blk"}, obs_blk(i), m_blk[i]);
            any_busy |= m_busy[i];
        end
        chk("free_cnt", int'(ofree_cnt), q[0].size());
        chk("all_free", int'(oall_free), int'(q[0].size() == int'(NB) && !any_busy));
        chk("err", int'(oerr), int'(m_err));
    endtask

    task automatic set_in(input bit rr, input bit er, input bit wr,
                          input bit rd, input bit ed, input bit wd,
                          input bit clr, input bit rs);
        ird_req = rr;  ienc_req = er;  iwr_req = wr;
        ird_done = rd; ienc_done = ed; iwr_done = wd;
        iclear = clr;  irst = rs;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Request each stage until it has mx grants; done follows each grant by one cycle
    task automatic flow(input int n, input int rmax, input int emax, input int wmax);
        int mx[3];
        int cnt[3];
        bit rq[3], dn[3];
        mx[0] = rmax; mx[1] = emax; mx[2] = wmax;
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            seq[i].delete();
        end
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 3; i++) begin
                dn[i] = m_grant[i];
                rq[i] = cnt[i] < mx[i];
            end
            set_in(rq[0], rq[1], rq[2], dn[0], dn[1], dn[2], 0, 0);
            cycle();
            for (int i = 0; i < 3; i++) begin
                if (m_grant[i]) cnt[i]++;
                if (obs_grant(i) != 0) seq[i].push_back(obs_blk(i));
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_seq(input string tag, input int s, input int len, input int first);
        chk({tag, "_count"}, seq[s].size(), len);
        for (int k = 0; k < len && k < seq[s].size(); k++)
            chk(tag, seq[s][k], (first + k) % int'(NB));
    endtask

    initial begin
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        chk("rst_free_cnt", int'(ofree_cnt), 4);
        chk("rst_all_free", int'(oall_free), 1);

        // Four reads then starvation while no block is free
        flow(20, 8, 0, 0);
        chk_seq("rd_seq", 0, 4, 0);
        chk("rd_starved_free", int'(ofree_cnt), 0);

        // Cipher and write every block back
        flow(40, 0, 8, 8);
        chk_seq("enc_seq", 1, 4, 0);
        chk_seq("wr_seq", 2, 4, 0);
        chk("pipe_all_free", int'(oall_free), 1);
        chk("pipe_free_cnt", int'(ofree_cnt), 4);

        // Pointer wrap-around over six blocks
        do_reset();
        flow(80, 6, 6, 6);
        chk_seq("wrap_seq", 0, 6, 0);
        chk("wrap_all_free", int'(oall_free), 1);

        // Done and request in the same cycle
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("dr_first", int'(ord_grant), 1);
        set_in(1, 0, 0, 1, 0, 0, 0, 0); cycle();
        chk("dr_same", int'(ord_grant), 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("dr_next", int'(ord_grant), 1);
        chk("dr_next_blk", int'(ord_blk), 1);
        set_in(0, 0, 0, 1, 0, 0, 0, 0); cycle();

        // Write done refills n_free=0; the read grant waits one cycle
        do_reset();
        flow(30, 4, 1, 0);
        set_in(0, 0, 1, 0, 0, 0, 0, 0); cycle();
        chk("wd_wr_grant", int'(owr_grant), 1);
        chk("wd_free0", int'(ofree_cnt), 0);
        set_in(1, 0, 0, 0, 0, 1, 0, 0); cycle();
        chk("wd_rd_same", int'(ord_grant), 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("wd_rd_next", int'(ord_grant), 1);
        set_in(0, 0, 0, 1, 0, 0, 0, 0); cycle();

        // Spurious cipher done, then clear
        do_reset();
        set_in(0, 0, 0, 0, 1, 0, 0, 0); cycle();
        chk("err_set", int'(oerr), 1);
        chk("err_free_cnt", int'(ofree_cnt), 4);
        set_in(0, 0, 0, 0, 0, 0, 1, 0); cycle();
        chk("clr_err", int'(oerr), 0);
        chk("clr_free_cnt", int'(ofree_cnt), 4);

        // Reset with all three stages busy
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        flow(30, 3, 2, 1);
        set_in(1, 1, 1, 0, 0, 0, 0, 0); cycle();
        chk("busy3_grants", int'({ord_grant, oenc_grant, owr_grant}), 7);
        set_in(1, 1, 1, 0, 0, 0, 0, 1); cycle();
        chk("rst_busy_grants", int'({ord_grant, oenc_grant, owr_grant}), 0);
        chk("rst_busy_free", int'(ofree_cnt), 4);
        chk("rst_busy_all_free", int'(oall_free), 1);
        chk("rst_busy_err", int'(oerr), 0);

        // Random traffic, including spurious dones, clears and resets
        for (int c = 0; c < 3000; c++) begin
            bit rq[3], dn[3];
            for (int i = 0; i < 3; i++) begin
                rq[i] = ($urandom_range(0, 1) == 1);
                dn[i] = m_busy[i] ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 63) == 0);
            end
            set_in(rq[0], rq[1], rq[2], dn[0], dn[1], dn[2],
                   $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_blk_sched
